// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: downstream, redirect, instruction-memory and fetch-output signals of the fetch unit.
interface if_fetch_unit_if;
  logic        ID_Stall;
  logic        Redirect;
  logic [31:0] PCSrcOut;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IF_Instruction;
  logic [31:0] PCOut;
  logic [31:0] PCAdd4;
  logic        IF_Valid;
  logic        IF_Stall;
  logic        IF_EXC_AdIF;
  modport master (
    input  ID_Stall, Redirect, PCSrcOut, imem_ack, imem_rdata,
    output imem_req, imem_addr, IF_Instruction, PCOut, PCAdd4, IF_Valid, IF_Stall, IF_EXC_AdIF
  );
  modport slave (
    output ID_Stall, Redirect, PCSrcOut, imem_ack, imem_rdata,
    input  imem_req, imem_addr, IF_Instruction, PCOut, PCAdd4, IF_Valid, IF_Stall, IF_EXC_AdIF
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: single-outstanding instruction fetch with redirect squashing and misaligned-PC trapping.
module if_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic         clock,
  input  logic         reset_n,
  if_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {REQ, HOLD, KILL} state_e;
  state_e      state_q;
  logic [31:0] pc_q, addr_q, instr_q;
  logic        valid_q, exc_q;
  logic        mis;
  assign mis                = addr_q[1:0] != 2'b00;
  assign bus.imem_req       = reset_n && (state_q == KILL || (state_q == REQ && !mis));
  assign bus.imem_addr      = addr_q;
  assign bus.IF_Instruction = instr_q;
  assign bus.PCOut          = pc_q;
  assign bus.PCAdd4         = pc_q + 32'd4;
  assign bus.IF_Valid       = valid_q;
  assign bus.IF_Stall       = !valid_q;
  assign bus.IF_EXC_AdIF    = exc_q;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= REQ;
      pc_q    <= RESET_VECTOR;
      addr_q  <= RESET_VECTOR;
      instr_q <= '0;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          // a misaligned REQ never issued a request, so a redirect simply retargets it
          if (bus.Redirect) begin
            pc_q <= bus.PCSrcOut;
            if (mis || bus.imem_ack) addr_q <= bus.PCSrcOut;
            else state_q <= KILL;
          end else if (mis) begin
            state_q <= HOLD;
            instr_q <= '0;
            valid_q <= 1'b1;
            exc_q   <= 1'b1;
          end else if (bus.imem_ack) begin
            state_q <= HOLD;
            instr_q <= bus.imem_rdata;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.Redirect) begin
            state_q <= REQ;
            pc_q    <= bus.PCSrcOut;
            addr_q  <= bus.PCSrcOut;
            valid_q <= 1'b0;
            exc_q   <= 1'b0;
          end else if (!exc_q && !bus.ID_Stall) begin
            state_q <= REQ;
            pc_q    <= pc_q + 32'd4;
            addr_q  <= pc_q + 32'd4;
            valid_q <= 1'b0;
          end
        end
        KILL: begin
          if (bus.Redirect) pc_q <= bus.PCSrcOut;
          if (bus.imem_ack) begin
            state_q <= REQ;
            addr_q  <= bus.Redirect ? bus.PCSrcOut : pc_q;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end
endmodule
